// File: rtl/gem_sync_pkg.sv
// Shared definitions for the GEM K-char sync monitors.
package gem_sync_pkg;

   localparam int CNTW = 4;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_SLIPPING = 2'd1,
      ST_UNLOCKED = 2'd2,
      ST_LOCKING  = 2'd3
   } sync_state_e;

endpackage

// File: rtl/gem_sync_fsm.sv
// One sync monitor: lock/unlock debounce FSM, sticky lost-sync flag and
// saturating raw-mismatch counter.
//
// state       | meaning
// ST_LOCKED   | in sync, no pending mismatches
// ST_SLIPPING | in sync, counting consecutive mismatches toward loss
// ST_UNLOCKED | sync lost, waiting for a first match
// ST_LOCKING  | out of sync, counting consecutive matches toward lock
module gem_sync_fsm
   import gem_sync_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2,
   parameter int ERRW       = 16
) (
   input  logic            i_clock,
   input  logic            i_rst,
   input  logic            i_resync,
   input  logic            i_clr,
   input  logic            i_match,
   output logic            o_synced,
   output logic            o_lostsync,
   output logic [ERRW-1:0] o_err_cnt
);

   localparam logic [CNTW-1:0] LOCK_N   = CNTW'(LOCK_CNT);
   localparam logic [CNTW-1:0] UNLOCK_N = CNTW'(UNLOCK_CNT);

   sync_state_e     r_state, w_state_nxt;
   logic [CNTW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic            r_synced, r_lost;
   logic [ERRW-1:0] r_err;
   logic            w_synced_nxt, w_enter_unl;

   assign w_cnt_inc = r_cnt + CNTW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (i_resync) begin
         w_state_nxt = ST_LOCKED;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_LOCKED: if (!i_match) begin
               w_state_nxt = (UNLOCK_CNT == 1) ? ST_UNLOCKED : ST_SLIPPING;
               w_cnt_nxt   = (UNLOCK_CNT == 1) ? '0 : CNTW'(1);
            end
            ST_SLIPPING: if (i_match) begin
               w_state_nxt = ST_LOCKED;
               w_cnt_nxt   = '0;
            end else if (w_cnt_inc == UNLOCK_N) begin
               w_state_nxt = ST_UNLOCKED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
            ST_UNLOCKED: if (i_match) begin
               w_state_nxt = (LOCK_CNT == 1) ? ST_LOCKED : ST_LOCKING;
               w_cnt_nxt   = (LOCK_CNT == 1) ? '0 : CNTW'(1);
            end
            ST_LOCKING: if (!i_match) begin
               w_state_nxt = ST_UNLOCKED;
               w_cnt_nxt   = '0;
            end else if (w_cnt_inc == LOCK_N) begin
               w_state_nxt = ST_LOCKED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
            default: begin
               w_state_nxt = ST_LOCKED;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign w_synced_nxt = (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_SLIPPING);
   assign w_enter_unl  = (w_state_nxt == ST_UNLOCKED) && (r_state != ST_UNLOCKED);

   always_ff @(posedge i_clock or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_LOCKED;
         r_cnt    <= '0;
         r_synced <= 1'b1;
         r_lost   <= 1'b0;
         r_err    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_synced <= w_synced_nxt;
         if (i_resync)
            r_lost <= 1'b0;
         else if (w_enter_unl)
            r_lost <= 1'b1;
         // Counter sees every raw mismatch, even one masked from the FSM by resync.
         if (i_clr)
            r_err <= '0;
         else if (!i_match && (r_err != {ERRW{1'b1}}))
            r_err <= r_err + ERRW'(1);
      end
   end

   assign o_synced   = r_synced;
   assign o_lostsync = r_lost;
   assign o_err_cnt  = r_err;

endmodule

// File: rtl/gem_sync_mon_n.sv
// GEM K-char sync monitor for NCH chambers: per-chamber fiber comparison
// plus a super-chamber comparison of the chamber reference fibers.
module gem_sync_mon_n
   import gem_sync_pkg::*;
#(
   parameter int NCH        = 2,
   parameter int FPC        = 2,
   parameter int KW         = 8,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2,
   parameter int ERRW       = 16
) (
   input  logic                  i_clock,
   input  logic                  i_global_reset,
   input  logic                  i_ttc_resync,
   input  logic                  i_clr_counters,
   input  logic [NCH*FPC-1:0]    i_fiber_en,
   input  logic [NCH*FPC*KW-1:0] i_kchar,
   output logic [NCH-1:0]        o_ch_synced,
   output logic                  o_sc_synced,
   output logic [NCH-1:0]        o_ch_lostsync,
   output logic                  o_sc_lostsync,
   output logic [NCH*ERRW-1:0]   o_ch_err_cnt,
   output logic [ERRW-1:0]       o_sc_err_cnt
);

   logic [NCH-1:0] w_ch_match;
   logic           w_sc_match;

   // A disabled reference fiber makes every comparison against it pass.
   always_comb begin
      w_ch_match = '1;
      for (int c = 0; c < NCH; c++) begin
         for (int f = 1; f < FPC; f++) begin
            if (i_fiber_en[c*FPC] && i_fiber_en[c*FPC+f] &&
                (i_kchar[(c*FPC+f)*KW +: KW] != i_kchar[c*FPC*KW +: KW]))
               w_ch_match[c] = 1'b0;
         end
      end
   end

   always_comb begin
      w_sc_match = &w_ch_match;
      for (int c = 1; c < NCH; c++) begin
         if (i_fiber_en[c*FPC] && i_fiber_en[0] &&
             (i_kchar[c*FPC*KW +: KW] != i_kchar[0 +: KW]))
            w_sc_match = 1'b0;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      gem_sync_fsm #(
         .LOCK_CNT   (LOCK_CNT),
         .UNLOCK_CNT (UNLOCK_CNT),
         .ERRW       (ERRW)
      ) u_fsm (
         .i_clock    (i_clock),
         .i_rst      (i_global_reset),
         .i_resync   (i_ttc_resync),
         .i_clr      (i_clr_counters),
         .i_match    (w_ch_match[c]),
         .o_synced   (o_ch_synced[c]),
         .o_lostsync (o_ch_lostsync[c]),
         .o_err_cnt  (o_ch_err_cnt[c*ERRW +: ERRW])
      );
   end

   gem_sync_fsm #(
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT),
      .ERRW       (ERRW)
   ) u_sc_fsm (
      .i_clock    (i_clock),
      .i_rst      (i_global_reset),
      .i_resync   (i_ttc_resync),
      .i_clr      (i_clr_counters),
      .i_match    (w_sc_match),
      .o_synced   (o_sc_synced),
      .o_lostsync (o_sc_lostsync),
      .o_err_cnt  (o_sc_err_cnt)
   );

endmodule
